psram_bist: RTL and testbench
=============================

Name: psram_bist

Overview:
- Traffic generator and checker directly upstream of psram_controller, on the controller's user-side port (ram_en/rw_ctrl/addr_in/ram_data_in in; ram_wr_valid/ram_rd_valid/ram_data_out back).
- On start, writes NUM_BURSTS bursts of a deterministic byte-incrementing pattern, then reads all of them back and compares.
- Reports pass/fail, mismatch count and first-failure details.
- Used for board bring-up and as the stimulus stage in controller simulation.

Parameters:
- BIT_WIDTH, 16: PSRAM DQ width; user data width is 2*BIT_WIDTH.
- BURST_BEATS, 8: 2*BIT_WIDTH-bit beats per burst.
- NUM_BURSTS, 4: bursts per pass (>=1).
- BASE_ADDR, 32'd0: address of burst 0.
- ADDR_STEP, 32'd16: addr_in increment between bursts.
- SEED, 32'h04060103: pattern seed.
- TIMEOUT, 1024: max cycles per burst, counted from ram_en to the last beat.

Ports:
- ram_clk  in  1  user clock; same clock as the controller's ram_clk.
- ram_rst  in  1  asynchronous active-low reset.
- start  in  1  1-cycle pulse; starts a pass; ignored while busy.
- init_cable_complete  in  1  controller init finished.
- ctrl_idle  in  1  controller accepts a request.
- ram_wr_valid  in  1  controller consumes ram_data_in this cycle.
- ram_rd_valid  in  1  ram_data_out valid this cycle.
- ram_data_out  in  2*BIT_WIDTH  read beat.
- ram_en  out  1  1-cycle request strobe.
- rw_ctrl  out  1  1 = write, 0 = read.
- addr_in  out  32  burst start address.
- ram_data_in  out  2*BIT_WIDTH  write beat.
- busy  out  1  pass in progress.
- done  out  1  1-cycle pulse at pass end.
- pass  out  1  sticky result of last pass; 1 = no errors.
- err_cnt  out  16  mismatching beats; saturates at 16'hFFFF.
- err_timeout  out  1  sticky; a burst exceeded TIMEOUT.
- first_err_addr  out  32  addr_in of the burst holding the first mismatch.
- first_err_beat  out  8  beat index of the first mismatch within its burst.
- first_err_data  out  2*BIT_WIDTH  actual data of the first mismatch.

Behaviour:
- Reset values:
  - ram_en=0, rw_ctrl=1, addr_in=BASE_ADDR, ram_data_in=pattern(0), busy=0, done=0, pass=0.
  - err_cnt=0, err_timeout=0, first_err_* = 0.
  - State IDLE. Reset mid-pass aborts immediately; no done pulse.
- Pattern: pattern(i) has each byte lane n equal to SEED byte n + i[7:0], mod 256 per lane. i = b*BURST_BEATS + k (burst b, beat k).
- States:
  - IDLE: on start, clear err_cnt, err_timeout, first_err_* and pass. Set busy=1, b=0. Go to WAIT_INIT.
  - WAIT_INIT: wait for init_cable_complete=1, then go to WR_REQ.
  - WR_REQ: when init_cable_complete & ctrl_idle, pulse ram_en for exactly 1 cycle with rw_ctrl=1, addr_in=BASE_ADDR+b*ADDR_STEP, ram_data_in=pattern(b*BURST_BEATS). Go to WR_DATA.
  - WR_DATA: on each ram_wr_valid, k++ and ram_data_in advances to the next pattern word, registered. After beat BURST_BEATS-1 is consumed: if b<NUM_BURSTS-1, b++ and go to WR_REQ; else b=0 and go to RD_REQ.
  - RD_REQ: as WR_REQ, but rw_ctrl=0. Go to RD_DATA.
  - RD_DATA: on each ram_rd_valid, compare ram_data_out with pattern(i) in the same cycle.
    - Mismatch: err_cnt++ (saturating). If it is the first mismatch of the pass, latch first_err_addr/beat/data.
    - After beat BURST_BEATS-1: go to RD_REQ for the next burst, or to FINISH.
  - FINISH: pulse done for 1 cycle; pass = (err_cnt==0 & !err_timeout); busy=0; go to IDLE.
- Output hold:
  - addr_in and rw_ctrl stay stable from the ram_en cycle until the burst's last beat.
  - ram_en is never asserted in two consecutive cycles.
  - No new request is issued until ctrl_idle is seen high again after the last beat.
- Timeout:
  - A cycle counter is cleared on ram_en and compared against TIMEOUT in WR_DATA and RD_DATA.
  - Reaching TIMEOUT sets err_timeout and jumps to FINISH, which pulses done with pass=0.
- Stray beats: ram_wr_valid or ram_rd_valid outside its matching data state, or beats beyond BURST_BEATS, are ignored and counted as errors (err_cnt++).
- start while busy is ignored. start in the same cycle as FINISH is ignored; a new start is needed after done.
- Simultaneous ram_wr_valid and ram_rd_valid: only the one matching the current state is processed; the other is a stray error.

Decomposition:
- Shared package psram_bist_pkg holds:
  - state encoding constants: IDLE, WAIT_INIT, WR_REQ, WR_DATA, RD_REQ, RD_DATA, FINISH;
  - the pattern function (seed, index) returning a 2*BIT_WIDTH word.
- One natural sub-module: psram_bist_pattern, combinational. It maps a global beat index to the pattern word and is instanced once each for the write path and the compare path.

Test Plan:
- Ideal controller model, defaults, start pulse: 4 write requests at addresses 0,16,32,48, then 4 reads. First write beat is 32'h04060103, second is 32'h05070204. done pulses once; pass=1, err_cnt=0.
- Read model flips bit 0 of beat 3 in burst 2: err_cnt=1, first_err_addr=32, first_err_beat=3, first_err_data=pattern(19)^1, pass=0.
- Model never returns ram_rd_valid for burst 1: after exactly TIMEOUT cycles err_timeout=1, done pulses, pass=0, busy=0.
- Hold init_cable_complete low for 500 cycles after start, and ctrl_idle low for 3 cycles between bursts: no ram_en during the stalls, one ram_en per burst, addr_in stable throughout each burst.
- Assert reset in the middle of RD_DATA: all outputs return to reset values, no done pulse. A following start runs a clean pass with pass=1.
- Model returns 9 read beats for one burst: err_cnt=1 from the stray beat, pass=0. Also pulse start while busy: it is ignored.

Source files
------------

// File: rtl/psram_bist_pkg.sv
// psram_bist_pkg: FSM state encoding and the byte-incrementing test pattern.
package psram_bist_pkg;
  typedef enum logic [2:0] {IDLE, WAIT_INIT, WR_REQ, WR_DATA, RD_REQ, RD_DATA, FINISH} state_t;
  localparam int PAT_W = 64;
  // Each byte lane n is seed byte (n mod 4) plus the low byte of the beat index.
  function automatic logic [PAT_W-1:0] pattern(input logic [31:0] seed, input logic [7:0] idx);
    logic [PAT_W-1:0] w;
    for (int n = 0; n < PAT_W / 8; n++) w[8*n +: 8] = seed[8*(n%4) +: 8] + idx;
    return w;
  endfunction
endpackage

// File: rtl/psram_bist_pattern.sv
// psram_bist_pattern: maps a global beat index (mod 256) to its pattern word.
module psram_bist_pattern
  import psram_bist_pkg::*;
#(
  parameter int          DW   = 32,
  parameter logic [31:0] SEED = 32'h04060103
) (
  input  logic [7:0]    i_idx,
  output logic [DW-1:0] o_word
);
  assign o_word = DW'(pattern(SEED, i_idx));
endmodule

// File: rtl/psram_bist.sv
// psram_bist: writes NUM_BURSTS pattern bursts through the controller user port,
// reads them back, and reports pass/fail, error count and first-failure details.
module psram_bist
  import psram_bist_pkg::*;
#(
  parameter int          BIT_WIDTH   = 16,
  parameter int          BURST_BEATS = 8,
  parameter int          NUM_BURSTS  = 4,
  parameter logic [31:0] BASE_ADDR   = 32'd0,
  parameter logic [31:0] ADDR_STEP   = 32'd16,
  parameter logic [31:0] SEED        = 32'h04060103,
  parameter int          TIMEOUT     = 1024
) (
  input  logic                   ram_clk,
  input  logic                   ram_rst,
  input  logic                   start,
  input  logic                   init_cable_complete,
  input  logic                   ctrl_idle,
  input  logic                   ram_wr_valid,
  input  logic                   ram_rd_valid,
  input  logic [2*BIT_WIDTH-1:0] ram_data_out,
  output logic                   ram_en,
  output logic                   rw_ctrl,
  output logic [31:0]            addr_in,
  output logic [2*BIT_WIDTH-1:0] ram_data_in,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [15:0]            err_cnt,
  output logic                   err_timeout,
  output logic [31:0]            first_err_addr,
  output logic [7:0]             first_err_beat,
  output logic [2*BIT_WIDTH-1:0] first_err_data
);
  localparam int DW = 2 * BIT_WIDTH;
  state_t r_state, w_next;
  logic [31:0] r_b, r_k, r_tmo, r_addr, r_fa;
  logic [7:0] r_widx, r_ridx, r_fb;
  logic [15:0] r_err;
  logic [DW-1:0] r_fd, w_exp;
  logic r_rw, r_pass, r_tmo_err, r_have_first;
  logic w_start, w_wbeat, w_rbeat, w_last, w_last_burst, w_in_data, w_tmo, w_mis;
  logic [1:0] w_inc;
  logic [16:0] w_sum;

  psram_bist_pattern #(.DW(DW), .SEED(SEED)) u_wr_pat (.i_idx(r_widx), .o_word(ram_data_in));
  psram_bist_pattern #(.DW(DW), .SEED(SEED)) u_cmp_pat (.i_idx(r_ridx), .o_word(w_exp));

  assign w_start      = start & (r_state == IDLE);
  assign w_wbeat      = ram_wr_valid & (r_state == WR_DATA);
  assign w_rbeat      = ram_rd_valid & (r_state == RD_DATA);
  assign w_last       = r_k == 32'(BURST_BEATS - 1);
  assign w_last_burst = r_b == 32'(NUM_BURSTS - 1);
  assign w_in_data    = (r_state == WR_DATA) | (r_state == RD_DATA);
  // A last beat landing on the final allowed cycle still completes the burst.
  assign w_tmo        = w_in_data & (r_tmo == 32'(TIMEOUT - 1)) & ~((w_wbeat | w_rbeat) & w_last);
  assign w_mis        = w_rbeat & (ram_data_out != w_exp);
  assign w_inc        = 2'(w_mis) + 2'(ram_wr_valid & ~w_wbeat) + 2'(ram_rd_valid & ~w_rbeat);
  assign w_sum        = {1'b0, r_err} + {15'd0, w_inc};

  assign rw_ctrl        = r_rw;
  assign addr_in        = r_addr;
  assign pass           = r_pass;
  assign err_cnt        = r_err;
  assign err_timeout    = r_tmo_err;
  assign first_err_addr = r_fa;
  assign first_err_beat = r_fb;
  assign first_err_data = r_fd;

  always_ff @(posedge ram_clk or negedge ram_rst)
    if (!ram_rst) r_state <= IDLE;
    else r_state <= w_next;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:      w_next = start ? WAIT_INIT : IDLE;
      WAIT_INIT: w_next = init_cable_complete ? WR_REQ : WAIT_INIT;
      WR_REQ:    w_next = ram_en ? WR_DATA : WR_REQ;
      WR_DATA:   w_next = w_tmo ? FINISH : (w_wbeat & w_last) ? (w_last_burst ? RD_REQ : WR_REQ) : WR_DATA;
      RD_REQ:    w_next = ram_en ? RD_DATA : RD_REQ;
      RD_DATA:   w_next = w_tmo ? FINISH : (w_rbeat & w_last) ? (w_last_burst ? FINISH : RD_REQ) : RD_DATA;
      FINISH:    w_next = IDLE;
      default:   w_next = IDLE;
    endcase
  end

  always_comb begin
    ram_en = ((r_state == WR_REQ) | (r_state == RD_REQ)) & init_cable_complete & ctrl_idle;
    busy   = r_state != IDLE;
    done   = r_state == FINISH;
  end

  always_ff @(posedge ram_clk or negedge ram_rst) begin
    if (!ram_rst) begin
      r_b          <= 32'd0;
      r_k          <= 32'd0;
      r_tmo        <= 32'd0;
      r_addr       <= BASE_ADDR;
      r_widx       <= 8'd0;
      r_ridx       <= 8'd0;
      r_rw         <= 1'b1;
      r_pass       <= 1'b0;
      r_tmo_err    <= 1'b0;
      r_have_first <= 1'b0;
      r_err        <= 16'd0;
      r_fa         <= 32'd0;
      r_fb         <= 8'd0;
      r_fd         <= '0;
    end else begin
      r_err <= w_start ? 16'd0 : w_sum[16] ? 16'hFFFF : w_sum[15:0];
      if (w_start) begin
        r_b          <= 32'd0;
        r_k          <= 32'd0;
        r_widx       <= 8'd0;
        r_ridx       <= 8'd0;
        r_addr       <= BASE_ADDR;
        r_rw         <= 1'b1;
        r_pass       <= 1'b0;
        r_tmo_err    <= 1'b0;
        r_have_first <= 1'b0;
        r_fa         <= 32'd0;
        r_fb         <= 8'd0;
        r_fd         <= '0;
      end
      if (ram_en) begin
        r_tmo <= 32'd1;
        r_k   <= 32'd0;
      end else if (w_in_data) r_tmo <= r_tmo + 32'd1;
      if (w_wbeat) r_widx <= r_widx + 8'd1;
      if (w_rbeat) r_ridx <= r_ridx + 8'd1;
      if (w_wbeat | w_rbeat) begin
        r_k <= w_last ? 32'd0 : r_k + 32'd1;
        if (w_last) begin
          r_b    <= w_last_burst ? 32'd0 : r_b + 32'd1;
          r_addr <= w_last_burst ? BASE_ADDR : r_addr + ADDR_STEP;
          if (w_wbeat & w_last_burst) r_rw <= 1'b0;
        end
      end
      if (w_mis & ~r_have_first) begin
        r_have_first <= 1'b1;
        r_fa         <= r_addr;
        r_fb         <= r_k[7:0];
        r_fd         <= ram_data_out;
      end
      if (w_tmo) r_tmo_err <= 1'b1;
      if (r_state == FINISH) r_pass <= (r_err == 16'd0) & ~r_tmo_err;
    end
  end
endmodule

// File: tb/tb_psram_bist.sv
// tb_psram_bist: table-driven and randomized passes against an ideal controller
// model with a byte-lane pattern reference and a write-then-read memory.
module tb_psram_bist;
  localparam int          DW = 32, BEATS = 8, NB = 4, TIMEOUT = 1024;
  localparam logic [31:0] BASE = 32'd0, STEP = 32'd16, SEED = 32'h04060103;

  typedef struct {
    int init_delay; int idle_gap; int max_gap;
    int flip_b; int flip_k; logic [31:0] flip_m;
    int drop_b; int extra_b; bit start_busy;
    bit exp_pass; int exp_err; bit exp_tmo;
    logic [31:0] exp_fa; int exp_fb; logic [31:0] exp_fd; int exp_nreq;
  } vec_t;

  logic clk = 0, ram_rst, start, init, ctrl_idle, wr_v, rd_v;
  logic [DW-1:0] rd_data, ram_data_in, first_err_data;
  logic ram_en, rw_ctrl, busy, done, pass, err_timeout;
  logic [31:0] addr_in, first_err_addr;
  logic [15:0] err_cnt;
  logic [7:0] first_err_beat;

  int n_vec = 0, n_err = 0, cyc = 0, en_cyc = 0, done_cnt = 0, bad_en = 0;
  bit prev_en = 0;
  int pass_id = 0, k_idle_gap = 0, k_max_gap = 0, k_flip_b = -1, k_flip_k = 0, k_drop_b = -1, k_extra_b = -1;
  logic [31:0] k_flip_m = 0;
  int m_pass = -1, m_wi = 0, m_ri = 0, m_rbeats = 0, m_bad = 0, m_n = 0, m_nb = 0;
  logic m_rw;
  logic [31:0] m_a, m_w0 = 0, m_w1 = 0;
  logic [32:0] req_q[$];
  logic [31:0] mem[int];
  vec_t tbl[5];

  always #5 clk = ~clk;

  psram_bist #(.BIT_WIDTH(16), .BURST_BEATS(BEATS), .NUM_BURSTS(NB), .BASE_ADDR(BASE),
               .ADDR_STEP(STEP), .SEED(SEED), .TIMEOUT(TIMEOUT)) dut (
    .ram_clk(clk), .ram_rst(ram_rst), .start(start), .init_cable_complete(init),
    .ctrl_idle(ctrl_idle), .ram_wr_valid(wr_v), .ram_rd_valid(rd_v), .ram_data_out(rd_data),
    .ram_en(ram_en), .rw_ctrl(rw_ctrl), .addr_in(addr_in), .ram_data_in(ram_data_in),
    .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt), .err_timeout(err_timeout),
    .first_err_addr(first_err_addr), .first_err_beat(first_err_beat), .first_err_data(first_err_data));

  function automatic logic [31:0] pat(input int i);
    logic [31:0] s, w;
    s = SEED;
    for (int n = 0; n < 4; n++) w[8*n +: 8] = 8'((int'(s[8*n +: 8]) + i) % 256);
    return w;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (ram_en) begin
      en_cyc = cyc;
      if (!init || !ctrl_idle || prev_en) bad_en++;
    end
    if (done) done_cnt++;
    prev_en = ram_en;
  end

  // Ideal controller: one request at a time, beats with random gaps, reads from memory.
  initial begin : ctrl_model
    ctrl_idle = 1; wr_v = 0; rd_v = 0; rd_data = 0;
    forever begin
      @(negedge clk);
      if (pass_id != m_pass) begin
        m_pass = pass_id; m_wi = 0; m_ri = 0; m_rbeats = 0;
      end
      if (ram_rst && ram_en) begin
        m_rw = rw_ctrl; m_a = addr_in; m_n = m_rw ? m_wi : m_ri;
        req_q.push_back({m_rw, m_a});
        @(posedge clk); #1 ctrl_idle = 0;
        m_nb = (!m_rw && m_n == k_extra_b) ? BEATS + 1 : (!m_rw && m_n == k_drop_b) ? 0 : BEATS;
        for (int k = 0; k < m_nb; k++) begin
          repeat ($urandom_range(k_max_gap)) begin @(posedge clk); #1; end
          if (!ram_rst) break;
          if (m_rw) wr_v = 1;
          else begin
            rd_v = 1;
            rd_data = (k < BEATS && mem.exists(m_a * 64 + k)) ? mem[m_a * 64 + k] : 32'hDEADBEEF;
            if (m_n == k_flip_b && k == k_flip_k) rd_data ^= k_flip_m;
          end
          @(negedge clk);
          if (ram_rst && k < BEATS && (addr_in !== m_a || rw_ctrl !== m_rw)) m_bad++;
          if (m_rw) begin
            if (ram_data_in !== pat(m_n * BEATS + k)) m_bad++;
            mem[m_a * 64 + k] = ram_data_in;
            if (m_n == 0 && k == 0) m_w0 = ram_data_in;
            if (m_n == 0 && k == 1) m_w1 = ram_data_in;
          end else m_rbeats++;
          @(posedge clk); #1 wr_v = 0; rd_v = 0;
        end
        if (m_rw) m_wi++; else m_ri++;
        if (m_nb == 0)
          for (int c = 0; c < 4 * TIMEOUT && busy && ram_rst; c++) begin @(posedge clk); #1; end
        repeat (k_idle_gap) begin @(posedge clk); #1; end
        ctrl_idle = 1;
      end
    end
  end

  task automatic set_knobs(input vec_t v);
    k_idle_gap = v.idle_gap; k_max_gap = v.max_gap; k_flip_b = v.flip_b; k_flip_k = v.flip_k;
    k_flip_m = v.flip_m; k_drop_b = v.drop_b; k_extra_b = v.extra_b;
    pass_id++;
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, " ram_en"}, ram_en, 0);
    chk({nm, " rw_ctrl"}, rw_ctrl, 1);
    chk({nm, " addr_in"}, addr_in, BASE);
    chk({nm, " ram_data_in"}, ram_data_in, pat(0));
    chk({nm, " busy"}, busy, 0);
    chk({nm, " done"}, done, 0);
    chk({nm, " pass"}, pass, 0);
    chk({nm, " err_cnt"}, err_cnt, 0);
    chk({nm, " err_timeout"}, err_timeout, 0);
    chk({nm, " first_err"}, {first_err_addr, first_err_beat, first_err_data[23:0]}, 0);
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    int base_done, base_bad, base_m, base_req, tdone;
    bit got;
    base_done = done_cnt; base_bad = bad_en; base_m = m_bad; base_req = req_q.size();
    set_knobs(v);
    if (v.init_delay > 0) init = 0;
    @(negedge clk) start = 1;
    @(negedge clk) start = 0;
    repeat (v.init_delay) @(negedge clk);
    init = 1;
    got = 0; tdone = 0;
    for (int c = 0; c < 30000 && !got; c++) begin
      @(negedge clk);
      start = v.start_busy && c == 40;
      if (done) begin got = 1; tdone = cyc; end
    end
    start = 0;
    chk({nm, " done seen"}, got, 1);
    if (v.exp_tmo) chk({nm, " timeout latency"}, tdone - en_cyc, TIMEOUT);
    @(negedge clk);
    chk({nm, " busy after"}, busy, 0);
    chk({nm, " done width"}, done, 0);
    chk({nm, " pass"}, pass, v.exp_pass);
    chk({nm, " err_cnt"}, err_cnt, v.exp_err);
    chk({nm, " err_timeout"}, err_timeout, v.exp_tmo);
    chk({nm, " first_err_addr"}, first_err_addr, v.exp_fa);
    chk({nm, " first_err_beat"}, first_err_beat, v.exp_fb);
    chk({nm, " first_err_data"}, first_err_data, v.exp_fd);
    repeat (5) @(negedge clk);
    chk({nm, " done pulses"}, done_cnt - base_done, 1);
    chk({nm, " request rules"}, bad_en - base_bad, 0);
    chk({nm, " beat data/hold"}, m_bad - base_m, 0);
    chk({nm, " request count"}, req_q.size() - base_req, v.exp_nreq);
    for (int j = 0; j < v.exp_nreq && base_req + j < req_q.size(); j++)
      chk($sformatf("%s req%0d", nm, j), req_q[base_req + j], {j < NB, BASE + 32'(j % NB) * STEP});
    chk({nm, " write beat0"}, m_w0, 32'h04060103);
    chk({nm, " write beat1"}, m_w1, 32'h05070204);
  endtask

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t v;
    int base_done;
    bit reached;
    ram_rst = 0; start = 0; init = 1;
    tbl[0] = '{0, 0, 0, -1, 0, 0, -1, -1, 0, 1, 0, 0, 0, 0, 0, 8};
    tbl[1] = '{0, 0, 1, 2, 3, 32'h1, -1, -1, 0, 0, 1, 0, 32'd32, 3, pat(19) ^ 32'h1, 8};
    tbl[2] = '{0, 0, 0, -1, 0, 0, 1, -1, 0, 0, 0, 1, 0, 0, 0, 6};
    tbl[3] = '{500, 3, 2, -1, 0, 0, -1, -1, 0, 1, 0, 0, 0, 0, 0, 8};
    tbl[4] = '{0, 1, 1, -1, 0, 0, -1, 1, 1, 0, 1, 0, 0, 0, 0, 8};
    repeat (3) @(negedge clk);
    chk_reset("in_reset");
    ram_rst = 1;
    repeat (2) @(negedge clk);
    chk_reset("after_reset");
    foreach (tbl[i]) run_vec(tbl[i], $sformatf("vec%0d", i));
    for (int r = 0; r < 4; r++) begin
      v = tbl[0];
      v.max_gap = $urandom_range(3); v.idle_gap = $urandom_range(3);
      v.flip_b = $urandom_range(NB - 1); v.flip_k = $urandom_range(BEATS - 1);
      v.flip_m = $urandom; if (v.flip_m == 0) v.flip_m = 32'h80;
      v.exp_pass = 0; v.exp_err = 1;
      v.exp_fa = BASE + 32'(v.flip_b) * STEP; v.exp_fb = v.flip_k;
      v.exp_fd = pat(v.flip_b * BEATS + v.flip_k) ^ v.flip_m;
      run_vec(v, $sformatf("rand%0d", r));
    end
    set_knobs(tbl[0]);
    @(negedge clk) start = 1;
    @(negedge clk) start = 0;
    reached = 0;
    for (int c = 0; c < 5000 && !reached; c++) begin
      @(negedge clk);
      reached = m_pass == pass_id && m_rbeats >= 3;
    end
    chk("abort reached RD_DATA", reached, 1);
    ram_rst = 0;
    #1 chk_reset("abort");
    base_done = done_cnt;
    repeat (3) @(negedge clk);
    ram_rst = 1;
    repeat (5) @(negedge clk);
    chk("abort no done", done_cnt - base_done, 0);
    chk("abort idle", busy, 0);
    run_vec(tbl[0], "post_abort");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
